// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Geometry must tile the operand exactly with at least one chunk.
    function automatic bit geometry_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Valid/ready operand and result bundle for serial_adder.
interface serial_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, s, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, s, c_out, overflow
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/serial_adder_chunk_adder.sv
// CHUNK-bit ripple adder built from full_adder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module chunk_adder #(parameter int CHUNK = 4) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle a+b+c_in: one CHUNK-wide slice per clock with a registered
// carry, result held until the consumer takes it.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_geom_bad
        $error("serial_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_out_q, ovf_q, out_valid_q, in_ready_q;

    logic [CHUNK-1:0] x_chunk, y_chunk, sum_chunk;
    logic             co_chunk, msb_chunk;

    assign x_chunk = a_q[idx*CHUNK +: CHUNK];
    assign y_chunk = b_q[idx*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x     (x_chunk),
        .y     (y_chunk),
        .ci    (carry),
        .sum   (sum_chunk),
        .co    (co_chunk),
        .c_msb (msb_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && in_ready_q) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    carry      <= bus.c_in;
                    idx        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= CALC;
                end
                CALC: begin
                    s_q[idx*CHUNK +: CHUNK] <= sum_chunk;
                    carry                   <= co_chunk;
                    // Last slice's internal carry is the carry into the MSB.
                    if (idx == LAST) begin
                        c_out_q     <= co_chunk;
                        ovf_q       <= co_chunk ^ msb_chunk;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 16/4 vectors with backpressure and reset,
// plus an exhaustive sweep of a 3/1 instance.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    serial_adder_if #(.WIDTH(16)) bus16 ();
    serial_adder_if #(.WIDTH(3))  bus3 ();

    serial_adder #(.WIDTH(16), .CHUNK(4)) u_add16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    serial_adder #(.WIDTH(3),  .CHUNK(1)) u_add3  (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Starts and ends at a negedge; operands are scrambled during CALC.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic eco, input logic eov,
                         input int hold, input string tag);
        int cyc;
        chk({tag, " ready"}, bus16.in_ready, 1);
        bus16.in_valid  = 1'b1;
        bus16.a         = av;
        bus16.b         = bv;
        bus16.c_in      = ci;
        bus16.out_ready = 1'b0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.a        = ~av;
        bus16.b        = ~bv;
        bus16.c_in     = ~ci;
        cyc = 0;
        while (!bus16.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " lat"}, cyc, 4);
        chk({tag, " s"}, bus16.s, es);
        chk({tag, " cout"}, bus16.c_out, eco);
        chk({tag, " ovf"}, bus16.overflow, eov);
        chk({tag, " busy"}, bus16.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a        = 16'(i * 16'h1111 + 7);
            bus16.b        = 16'(~(i * 16'h0101));
            @(negedge clk);
            chk({tag, " hold s"}, bus16.s, es);
            chk({tag, " hold cout"}, bus16.c_out, eco);
            chk({tag, " hold vld"}, bus16.out_valid, 1);
            chk({tag, " hold rdy"}, bus16.in_ready, 0);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " xfer vld"}, bus16.out_valid, 0);
        chk({tag, " xfer rdy"}, bus16.in_ready, 1);
        bus16.out_ready = 1'b0;
    endtask

    task automatic run3(input logic [2:0] av, input logic [2:0] bv, input logic ci);
        int cyc;
        logic [3:0] exp;
        string tag;
        tag = $sformatf("x3 %0d+%0d+%0d", av, bv, ci);
        exp = {1'b0, av} + {1'b0, bv} + {3'b0, ci};
        bus3.in_valid  = 1'b1;
        bus3.a         = av;
        bus3.b         = bv;
        bus3.c_in      = ci;
        bus3.out_ready = 1'b0;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        bus3.a        = ~av;
        bus3.b        = ~bv;
        cyc = 0;
        while (!bus3.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " lat"}, cyc, 3);
        chk({tag, " sum"}, {bus3.c_out, bus3.s}, exp);
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.out_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.out_ready = 1'b0;
        bus3.in_valid  = 1'b0; bus3.a  = '0; bus3.b  = '0; bus3.c_in  = 1'b0; bus3.out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", bus16.in_ready, 1);
        chk("rst vld", bus16.out_valid, 0);
        chk("rst s", bus16.s, 0);
        chk("rst cout", bus16.c_out, 0);
        chk("rst ovf", bus16.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, "basic");
        run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "ripple");
        run16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0, "cin");
        run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "posovf");
        run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, "negovf");
        run16(16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0, 5, "bp");

        // Abort after two CALC edges; partial sum is nonzero by then.
        bus16.in_valid = 1'b1;
        bus16.a        = 16'h1234;
        bus16.b        = 16'h4321;
        bus16.c_in     = 1'b0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort ready", bus16.in_ready, 1);
        chk("abort vld", bus16.out_valid, 0);
        chk("abort s", bus16.s, 0);
        chk("abort cout", bus16.c_out, 0);
        chk("abort ovf", bus16.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run16(16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 0, "postrst");

        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run3(3'(ia), 3'(ib), 1'(ic));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that computes `a + b + c_in` over `WIDTH` bits, processing `CHUNK` bits per clock through a single chunk-wide ripple slice with a registered carry. It is the sequential, width-generic successor of the single-bit `full_adder` cell. It serves as the area-lean arithmetic unit behind valid/ready datapaths in the design. Results are held at the output until the downstream consumer accepts them.

## Interface
- `WIDTH`, 16, operand and sum width in bits; must be a multiple of `CHUNK`.
- `CHUNK`, 4, bits added per clock, with 1 ≤ `CHUNK` ≤ `WIDTH`; `NCHUNK = WIDTH/CHUNK`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept operands; `in_ready = (state == IDLE)`.
- `a`  in  `WIDTH`  operand A, unsigned or two's complement.
- `b`  in  `WIDTH`  operand B.
- `c_in`  in  1  carry-in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `s`  out  `WIDTH`  sum, registered.
- `c_out`  out  1  carry out of the MSB.
- `overflow`  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `a`, `b` and `c_in` into the operand registers and the carry register; set `idx` = 0; go to CALC.
- **CALC**
  - Each cycle, add chunk `idx` (bits `[idx*CHUNK +: CHUNK]`) of A and B together with the carry register.
  - Write the result into the same slice of `s`; update the carry register.
  - When the last chunk (`idx == NCHUNK-1`) is processed: capture `c_out` and `overflow`, then go to DONE. Otherwise increment `idx`.
- **DONE**
  - `out_valid` = 1.
  - `s`, `c_out` and `overflow` stay stable while `out_ready` = 0.
  - On `out_ready` = 1: go to IDLE.
- `in_valid`, `a`, `b` and `c_in` are ignored outside IDLE. An operand change during CALC has no effect.
- `s` is not defined as the final sum until `out_valid` = 1. Partial chunks are visible during CALC and must not be consumed.
- Arithmetic is modulo 2^`WIDTH`. The carry register is 1 bit. `overflow` uses the carry into bit `WIDTH-1`, which is taken from the final chunk's internal carry.
- Degenerate case `CHUNK == WIDTH` (`NCHUNK` = 1): CALC lasts exactly one cycle.
- Reset (`rst_n` = 0), at any time including mid-CALC or in DONE, aborts the current operation and discards it. Reset values:
  - state = IDLE, `idx` = 0, carry = 0
  - `s` = 0, `c_out` = 0, `overflow` = 0
  - `out_valid` = 0, `in_ready` = 1

## Timing
- The acceptance edge is E0. CALC occupies edges E1..E`NCHUNK`. `out_valid` rises after edge E`NCHUNK`.
- Latency: the result is visible `NCHUNK` cycles after acceptance.
- With `out_ready` held at 1, the transfer happens at edge E`NCHUNK+1`. `in_ready` is 1 in the following cycle, and the next acceptance is possible at E`NCHUNK+2`.
- Peak throughput is one result per `NCHUNK+2` cycles. There is no overlap of operations.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- `serial_adder_pkg` contains:
  - the state enum (IDLE, CALC, DONE)
  - the function `nchunk(WIDTH, CHUNK)`
  - an elaboration-time check that `WIDTH % CHUNK == 0`
- Sub-module `chunk_adder` (parameter `CHUNK`) contains:
  - inputs: `CHUNK`-bit `x`, `CHUNK`-bit `y`, and `ci`
  - outputs: `CHUNK`-bit `sum`, `co`, and `c_msb` (the carry into its top bit)
  - implementation: a ripple chain built from `full_adder` cells
- `serial_adder` contains the FSM, the operand, sum, carry and index registers, and one `chunk_adder` instance.

## Test plan
- WIDTH=16, CHUNK=4: a=0x1234, b=0x4321, c_in=0 → s=0x5555, c_out=0, overflow=0; `out_valid` rises exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, c_in=0 → s=0x0000, c_out=1, overflow=0; this checks carry propagation across all four chunks.
- a=0x7FFF, b=0x0001, c_in=0 → s=0x8000, c_out=0, overflow=1. Then a=0x8000, b=0x8000 → s=0x0000, c_out=1, overflow=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 and changing operands.
  - During the hold: s, c_out and `out_valid` stay stable, `in_ready`=0, and no new operation is accepted.
  - After `out_ready`=1: the transfer completes and `in_ready`=1 on the next cycle.
- Assert `rst_n`=0 after 2 CALC cycles → all outputs take their reset values immediately. Then a=0x0001, b=0x0001, c_in=1 → s=0x0003, c_out=0.
- WIDTH=3, CHUNK=1: exhaustive run over all 128 combinations of a, b and c_in; each case must give {c_out,s} = a+b+c_in, with a 3-cycle latency.
